// File: rtl/cdf_store_packer_if.sv
// Memory write-bus bundle for cdf_store_packer.
// The packer drives it through the master modport; the bus arbiter/memory uses slave.
interface cdf_store_packer_if #(
   parameter int BUS_W  = 128,
   parameter int ADDR_W = 16,
   parameter int LANES  = 4
);
   logic              WriteReq;
   logic              WriteGrant;
   logic [BUS_W-1:0]  WriteBus;
   logic [ADDR_W-1:0] WriteAddress;
   logic [LANES-1:0]  WriteMask;
   logic              WriteEnable;

   modport master (
      output WriteReq, WriteBus, WriteAddress, WriteMask, WriteEnable,
      input  WriteGrant
   );
   modport slave (
      input  WriteReq, WriteBus, WriteAddress, WriteMask, WriteEnable,
      output WriteGrant
   );
endinterface

// File: rtl/cdf_store_packer.sv
// CDF write-back packer: merges per-bin results into wide words, queues them, writes on grant.
// Optional CDF_STORE_TRISTATE_EN: the write bus floats outside the WriteEnable cycle.
module cdf_store_packer_lane #(
   parameter int RESULT_W = 20,
   parameter int SLOT_W   = 32
) (
   input  logic                sel,
   input  logic                fresh,
   input  logic [RESULT_W-1:0] result,
   input  logic [SLOT_W-1:0]   slot_q,
   input  logic                mask_q,
   output logic [SLOT_W-1:0]   slot_d,
   output logic                mask_d
);
   // A fresh word clears every slot; the selected lane always takes the new result.
   always_comb begin
      slot_d = fresh ? '0 : slot_q;
      mask_d = mask_q & ~fresh;
      if (sel) begin
         slot_d = SLOT_W'(result);
         mask_d = 1'b1;
      end
   end
endmodule

module cdf_store_packer #(
   parameter int RESULT_W   = 20,
   parameter int SLOT_W     = 32,
   parameter int BUS_W      = 128,
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                StartIn,
   input  logic [RESULT_W-1:0] ResultIn,
   input  logic [ADDR_W-1:0]   StoreAddressIn,
   input  logic                FlushIn,
   output logic                ReadyOut,
   output logic                BusyOut,
   output logic                OverflowErr,
   cdf_store_packer_if.master  wr
);
   localparam int LANES  = BUS_W / SLOT_W;
   localparam int LANE_W = $clog2(LANES);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [LANES-1:0][SLOT_W-1:0] data;
      logic [ADDR_W-1:0]            addr;
      logic [LANES-1:0]             mask;
   } entry_t;

   logic [LANES-1:0][SLOT_W-1:0] acc_data, acc_data_d;
   logic [LANES-1:0]             acc_mask, acc_mask_d, lane_sel;
   logic [ADDR_W-1:0]            acc_addr;
   logic                         acc_vld;

   entry_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     count;

   logic [BUS_W-1:0]   bus_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [LANES-1:0]   mask_q;
   logic               we_q;
   logic               ovf_q;

   logic [LANE_W-1:0]  lane;
   logic [ADDR_W-1:0]  word;
   logic               full, accept, push, pop, fresh;

   assign lane   = StoreAddressIn[LANE_W-1:0];
   assign word   = StoreAddressIn >> LANE_W;
   assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign accept = StartIn & ~full;
   assign push   = acc_vld & ~full &
                   ((&acc_mask) | (accept & (word != acc_addr)) | FlushIn);
   assign pop    = (count != '0) & wr.WriteGrant;
   assign fresh  = push | ~acc_vld;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_sel[i] = accept & (lane == LANE_W'(i));
      cdf_store_packer_lane #(.RESULT_W(RESULT_W), .SLOT_W(SLOT_W)) u_lane (
         .sel    (lane_sel[i]),
         .fresh  (fresh),
         .result (ResultIn),
         .slot_q (acc_data[i]),
         .mask_q (acc_mask[i]),
         .slot_d (acc_data_d[i]),
         .mask_d (acc_mask_d[i])
      );
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_data <= '0;
         acc_mask <= '0;
         acc_addr <= '0;
         acc_vld  <= 1'b0;
      end else begin
         acc_data <= acc_data_d;
         acc_mask <= acc_mask_d;
         acc_vld  <= accept | (acc_vld & ~push);
         if (accept) acc_addr <= word;
      end
   end

   // Storage needs no reset: pointers and count define what is live.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= '{data: acc_data, addr: acc_addr, mask: acc_mask};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_q  <= '0;
         addr_q <= '0;
         mask_q <= '0;
         we_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (pop) begin
            bus_q  <= mem[rd_ptr].data;
            addr_q <= mem[rd_ptr].addr;
            mask_q <= mem[rd_ptr].mask;
            we_q   <= 1'b1;
         end else begin
            bus_q  <= '0;
            addr_q <= '0;
            mask_q <= '0;
            we_q   <= 1'b0;
         end
         if (StartIn & full) ovf_q <= 1'b1;
      end
   end

   assign ReadyOut    = ~full;
   assign BusyOut     = acc_vld | (count != '0) | we_q;
   assign OverflowErr = ovf_q;
   assign wr.WriteReq = (count != '0);

`ifdef CDF_STORE_TRISTATE_EN
   assign wr.WriteBus     = we_q ? bus_q  : {BUS_W{1'bz}};
   assign wr.WriteAddress = we_q ? addr_q : {ADDR_W{1'bz}};
   assign wr.WriteMask    = we_q ? mask_q : {LANES{1'bz}};
   assign wr.WriteEnable  = we_q ? 1'b1   : 1'bz;
`else
   assign wr.WriteBus     = bus_q;
   assign wr.WriteAddress = addr_q;
   assign wr.WriteMask    = mask_q;
   assign wr.WriteEnable  = we_q;
`endif
endmodule

// File: tb/tb_cdf_store_packer.sv
// Scoreboard bench for cdf_store_packer (LANES=4, FIFO_DEPTH=4): stimulus queues expected
// writes, a negedge monitor pops and compares every WriteEnable cycle.
module tb_cdf_store_packer;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        StartIn = 1'b0;
   logic [19:0] ResultIn = '0;
   logic [15:0] StoreAddressIn = '0;
   logic        FlushIn = 1'b0;
   logic        ReadyOut, BusyOut, OverflowErr;

   cdf_store_packer_if #(.BUS_W(128), .ADDR_W(16), .LANES(4)) wr ();

   cdf_store_packer dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .StartIn        (StartIn),
      .ResultIn       (ResultIn),
      .StoreAddressIn (StoreAddressIn),
      .FlushIn        (FlushIn),
      .ReadyOut       (ReadyOut),
      .BusyOut        (BusyOut),
      .OverflowErr    (OverflowErr),
      .wr             (wr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0]  addr;
      logic [3:0]   mask;
      logic [127:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk1(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %b want %b", name, got, want);
      end
   endtask

   task automatic chkw(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [3:0] m,
                            input logic [31:0] s3, input logic [31:0] s2,
                            input logic [31:0] s1, input logic [31:0] s0);
      exp_t e;
      e.addr = a;
      e.mask = m;
      e.data = {s3, s2, s1, s0};
      sb.push_back(e);
   endtask

   task automatic sample(input logic [15:0] a, input logic [19:0] r);
      @(negedge clock);
      StartIn = 1'b1;
      StoreAddressIn = a;
      ResultIn = r;
      @(posedge clock);
      #1;
      StartIn = 1'b0;
   endtask

   task automatic flush();
      @(negedge clock);
      FlushIn = 1'b1;
      @(posedge clock);
      #1;
      FlushIn = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || BusyOut) && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk1({name, "_drained"}, (sb.size() == 0) && !BusyOut, 1'b1);
   endtask

   // Monitor: every WriteEnable cycle must match the next queued expectation.
   always @(negedge clock) begin
      if (reset_n && wr.WriteEnable === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h mask=%b data=%h",
                     wr.WriteAddress, wr.WriteMask, wr.WriteBus);
         end else begin
            mon_e = sb.pop_front();
            if (wr.WriteAddress !== mon_e.addr || wr.WriteMask !== mon_e.mask ||
                wr.WriteBus !== mon_e.data) begin
               errors++;
               $display("FAIL write got addr=%h mask=%b data=%h want addr=%h mask=%b data=%h",
                        wr.WriteAddress, wr.WriteMask, wr.WriteBus,
                        mon_e.addr, mon_e.mask, mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      wr.WriteGrant = 1'b0;
      #2;
      chk1("rst_we", wr.WriteEnable === 1'b1, 1'b0);
      chk1("rst_req", wr.WriteReq, 1'b0);
      chk1("rst_ready", ReadyOut, 1'b1);
      chk1("rst_busy", BusyOut, 1'b0);
      chk1("rst_ovf", OverflowErr, 1'b0);
`ifdef CDF_STORE_TRISTATE_EN
      chkw("rst_bus_z", wr.WriteBus, {128{1'bz}});
`else
      chkw("rst_bus", wr.WriteBus, '0);
      chkw("rst_mask", 128'(wr.WriteMask), '0);
`endif
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Sequential fill: one full write two edges after the last sample.
      wr.WriteGrant = 1'b1;
      expect_wr(16'h0004, 4'b1111, 32'd4, 32'd3, 32'd2, 32'd1);
      for (int j = 0; j < 4; j++) sample(16'h0010 + 16'(j), 20'(j + 1));
      @(posedge clock); #1;
      chk1("fill_we_edge1", wr.WriteEnable === 1'b1, 1'b0);
      @(posedge clock); #1;
      chk1("fill_we_edge2", wr.WriteEnable === 1'b1, 1'b1);
      drain("fill");

      // Word change pushes the old word; the new one waits for FlushIn.
      expect_wr(16'h0008, 4'b0010, 32'd0, 32'd0, 32'd7, 32'd0);
      expect_wr(16'h000C, 4'b0001, 32'd0, 32'd0, 32'd0, 32'd9);
      sample(16'h0021, 20'd7);
      sample(16'h0030, 20'd9);
      repeat (4) @(posedge clock);
      #1;
      chk1("wchg_held", BusyOut, 1'b1);
      chk1("wchg_one_left", sb.size() == 1, 1'b1);
      flush();
      drain("wchg");

      // Backpressure: four full words fill the FIFO, later samples overflow.
      wr.WriteGrant = 1'b0;
      for (int k = 0; k < 4; k++)
         expect_wr(16'h0010 + 16'(k), 4'b1111, 32'(16*k + 4), 32'(16*k + 3),
                   32'(16*k + 2), 32'(16*k + 1));
      expect_wr(16'h0014, 4'b0001, 32'd0, 32'd0, 32'd0, 32'd65);
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < 4; j++)
            sample(16'h0040 + 16'(4*k + j), 20'(16*k + j + 1));
      chk1("bp_ready_low", ReadyOut, 1'b0);
      chk1("bp_ovf", OverflowErr, 1'b1);
      chk1("bp_req", wr.WriteReq, 1'b1);
      @(negedge clock);
      wr.WriteGrant = 1'b1;
      @(posedge clock); #1;
      chk1("bp_we1", wr.WriteEnable === 1'b1, 1'b1);
      chk1("bp_ready_back", ReadyOut, 1'b1);
      for (int p = 2; p <= 4; p++) begin
         @(posedge clock); #1;
         chk1("bp_we_b2b", wr.WriteEnable === 1'b1, 1'b1);
      end
      @(posedge clock); #1;
      chk1("bp_we_end", wr.WriteEnable === 1'b1, 1'b0);
      flush();
      drain("bp");
      chk1("bp_ovf_sticky", OverflowErr, 1'b1);

      // Lane overwrite: later result replaces the earlier one in the same slot.
      expect_wr(16'h0001, 4'b0010, 32'd0, 32'd0, 32'd8, 32'd0);
      sample(16'h0005, 20'd3);
      sample(16'h0005, 20'd8);
      flush();
      drain("ovr");
`ifdef CDF_STORE_TRISTATE_EN
      chkw("idle_bus_z", wr.WriteBus, {128{1'bz}});
`else
      chkw("idle_bus", wr.WriteBus, '0);
`endif

      // Reset with two entries pending discards them.
      wr.WriteGrant = 1'b0;
      for (int j = 0; j < 8; j++) sample(16'h0060 + 16'(j), 20'(j + 100));
      repeat (3) @(posedge clock);
      #1;
      chk1("rst_mid_req", wr.WriteReq, 1'b1);
      @(negedge clock);
      wr.WriteGrant = 1'b1;
      reset_n = 1'b0;
      #1;
      chk1("rst_mid_we", wr.WriteEnable === 1'b1, 1'b0);
      chk1("rst_mid_req_low", wr.WriteReq, 1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      chk1("post_rst_busy", BusyOut, 1'b0);
      chk1("post_rst_ovf", OverflowErr, 1'b0);
      chk1("post_rst_req", wr.WriteReq, 1'b0);
      chk1("post_rst_ready", ReadyOut, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cdf_store_packer.md
# cdf_store_packer

Parametrised write-back stage of the CDF pipeline. Collects per-bin results from the compute stage and packs several into one wide memory word. Buffers packed words in a small FIFO and arbitrates for the shared memory write bus with a request/grant handshake. Replaces the single-result-per-write store stage, so one bus write now carries up to LANES results and the stage can absorb grant latency.

## Interface
- RESULT_W, 20, width of one result
- SLOT_W, 32, bus slot per result; RESULT_W ≤ SLOT_W, zero-extended
- BUS_W, 128, memory write bus width; LANES = BUS_W/SLOT_W (power of 2, ≥2)
- ADDR_W, 16, element (result) address width
- FIFO_DEPTH, 4, packed-word FIFO entries (power of 2, ≥2)

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- StartIn  in  1  result valid
- ResultIn  in  RESULT_W  result data
- StoreAddressIn  in  ADDR_W  element address
- FlushIn  in  1  force partial word out
- ReadyOut  out  1  stage can accept StartIn
- WriteReq  out  1  bus request
- WriteGrant  in  1  bus grant from arbiter
- WriteBus  out  BUS_W  packed data
- WriteAddress  out  ADDR_W  word address = element address >> log2(LANES)
- WriteMask  out  LANES  valid-slot mask, bit i = slot i
- WriteEnable  out  1  write strobe
- BusyOut  out  1  accumulator valid, FIFO non-empty, or write in flight
- OverflowErr  out  1  sticky: StartIn seen while ReadyOut low

## Operation
- Lane = StoreAddressIn[log2(LANES)-1:0]; word = StoreAddressIn >> log2(LANES). Slot i occupies WriteBus[i*SLOT_W +: SLOT_W].
- Accumulator holds data, word address, lane mask, valid bit.
- Accept = StartIn & ReadyOut. ReadyOut = FIFO not full (combinational from count).
- Push of the accumulator into the FIFO occurs at an edge when the accumulator is valid, the FIFO is not full, and any of the following holds:
  - the mask is all ones;
  - an accepted sample has a different word address;
  - FlushIn is high.
- Accepted sample with no push: merges into the accumulator. It sets its lane bit and overwrites the lane if already set.
- Accepted sample with a push: starts a fresh accumulator holding only that sample. FlushIn with a same-cycle accepted sample pushes the old contents; the new sample stays in the accumulator.
- Full FIFO: the accumulator holds and ReadyOut is low. A dropped StartIn sets OverflowErr, which is cleared only by reset.
- WriteReq = FIFO non-empty.
- Bus side (registered):
  - When WriteReq & WriteGrant at an edge: pop the head. WriteBus, WriteAddress and WriteMask load from the head, and WriteEnable goes high for the next cycle.
  - Otherwise WriteEnable is low and the data/address/mask registers clear to 0.
- Push and pop in the same cycle is legal; the count is unchanged.
- Reset values:
  - WriteEnable, WriteReq, BusyOut, OverflowErr, WriteMask, WriteBus, WriteAddress are all 0.
  - ReadyOut is 1.
  - Accumulator and FIFO are empty.
- Reset mid-operation discards all buffered data.

## Timing
- Accumulator push: the edge after the closing condition is visible. With a full mask formed at edge N, the push occurs at edge N+1.
- WriteReq rises in the cycle after the push edge.
- Grant sampled at edge M gives WriteEnable high for cycle M..M+1, with data stable in that cycle.
- Minimum latency from the last-lane StartIn edge to WriteEnable high: 2 cycles.
- Sustained grant gives one write per cycle; WriteReq stays high while entries remain.
- WriteGrant without WriteReq: ignored.
- Throughput: one accepted sample per cycle while the FIFO is not full.

## Configuration
- CDF_STORE_TRISTATE_EN defined: WriteBus, WriteAddress, WriteMask and WriteEnable are driven only during the WriteEnable cycle and are high-Z otherwise, including in reset. This supports a shared multi-driver bus.
- Not defined: all outputs are always driven, with the zero/low values given above. This supports a point-to-point or muxed bus.

## Test plan
- Sequential fill, LANES=4: StartIn at addr 0x0010..0x0013 with results 1..4, grant tied high → one write, WriteAddress=0x0004, mask 4'b1111, slots 1,2,3,4, WriteEnable 2 cycles after the last sample.
- Word change: addr 0x0021 then 0x0030 (results 7, 9), grant high → write addr 0x0008, mask 0010, slot1=7; the second sample stays in the accumulator until FlushIn → addr 0x000C, mask 0001.
- Backpressure: grant low, push 5 full words with FIFO_DEPTH=4 → ReadyOut low after the 4th push. A StartIn while low sets OverflowErr=1. Then raise grant → 4 back-to-back writes and ReadyOut returns high.
- Lane overwrite: addr 0x0005 result 3, then addr 0x0005 result 8, then FlushIn → single write, addr 0x0001, mask 0010, slot1=8.
- Reset mid-operation: 2 FIFO entries pending, assert reset_n low with grant high → WriteEnable and WriteReq go low immediately. After release, no writes occur, BusyOut=0 and OverflowErr=0.
- Tri-state, with CDF_STORE_TRISTATE_EN: WriteBus is Z when idle and valid only in the WriteEnable cycle. Without the macro, WriteBus is 0 when idle.
